// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: state encoding and alarm counter sizing.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to hold the value secs; never less than one.
    function automatic int unsigned alarm_w(input int unsigned secs);
        int unsigned w;
        w = 1;
        while ((secs >> w) != 0) w++;
        return w;
    endfunction

endpackage

// File: rtl/countdown_ctrl_edge_rise.sv
// Rising-edge detector: one history flop ANDed with the live level.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown-timer controller stepped by the 1 Hz divider output, with timed alarm.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset at zero instead of stopping.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ALARM_SECS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sec_clk,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic [CNT_W-1:0] preset,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state,
    output logic             alarm,
    output logic             done_pulse
);

    localparam int unsigned AW = alarm_w(ALARM_SECS);

    logic sec_tick, start_rise, pause_rise, clear_rise;

    edge_rise u_sec   (.clk(clk), .rst_n(rst_n), .d(sec_clk), .rise(sec_tick));
    edge_rise u_start (.clk(clk), .rst_n(rst_n), .d(start),   .rise(start_rise));
    edge_rise u_pause (.clk(clk), .rst_n(rst_n), .d(pause),   .rise(pause_rise));
    edge_rise u_clear (.clk(clk), .rst_n(rst_n), .d(clear),   .rise(clear_rise));

    state_t           state_q, state_n;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic [AW-1:0]    acnt_q, acnt_n;
    logic             done_q, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            acnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            rem_q   <= rem_n;
            acnt_q  <= acnt_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        rem_n   = rem_q;
        acnt_n  = acnt_q;
        done_n  = 1'b0;

        if (clear_rise) begin
            state_n = ST_IDLE;
            rem_n   = '0;
            acnt_n  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_rise && preset != '0) begin
                        rem_n   = preset;
                        state_n = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sec_tick) begin
                        // Alarm can still be counting here only after an auto-reload.
                        if (acnt_q != '0) acnt_n = acnt_q - AW'(1);
                        if (rem_q == CNT_W'(1)) begin
                            // Final tick overrides a coincident pause.
                            done_n = 1'b1;
                            acnt_n = AW'(ALARM_SECS);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (preset != '0) begin
                                rem_n = preset;
                            end else begin
                                rem_n   = '0;
                                state_n = ST_DONE;
                            end
`else
                            rem_n   = '0;
                            state_n = ST_DONE;
`endif
                        end else begin
                            rem_n = rem_q - CNT_W'(1);
                            if (pause_rise) state_n = ST_PAUSE;
                        end
                    end else if (pause_rise) begin
                        state_n = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start_rise || pause_rise) state_n = ST_RUN;
                end
                ST_DONE: begin
                    if (start_rise) begin
                        acnt_n = '0;
                        if (preset != '0) begin
                            rem_n   = preset;
                            state_n = ST_RUN;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else if (sec_tick && acnt_q != '0) begin
                        acnt_n = acnt_q - AW'(1);
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign remaining  = rem_q;
    assign state      = state_q;
    assign alarm      = (acnt_q != '0);
    assign done_pulse = done_q;

endmodule
